// File: rtl/lsu_if.sv
// CPU-side request/response and memory-side bus of the load/store unit.
// The LSU takes the slave view; the CPU/memory environment takes the master view.
interface lsu_if;
  // CPU request
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  // CPU response
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  // Word data memory port
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, wr, size, uns, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, wr, size, uns, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: byte/halfword/word loads with sign or zero extension,
// word stores in one write, sub-word stores by read-modify-write of the
// memory word, and optional rejection of misaligned accesses.
module lsu #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input logic clk,
  input logic rst,
  lsu_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic        wr_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;
  logic [31:0] merge_reg;

  logic        misaligned;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Size code 11 behaves as a word, so bit 1 alone identifies word accesses.
  assign misaligned = CHECK_ALIGN &&
                      (((bus.size == 2'b01) && bus.addr[0]) ||
                       (bus.size[1] && (bus.addr[1:0] != 2'b00)));

  // Extend the memory read according to the latched size and signedness.
  always_comb begin
    load_data = bus.mem_rdata;
    if (!size_reg[1]) begin
      if (size_reg[0])
        load_data = {{16{~uns_reg & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      else
        load_data = {{24{~uns_reg & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
    end
  end

  // Replace the low byte or half of the fetched word with the store data.
  always_comb begin
    merge_data = bus.mem_rdata;
    if (size_reg[0])
      merge_data[15:0] = wdata_reg[15:0];
    else
      merge_data[7:0] = wdata_reg[7:0];
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state selection; requests are only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          if (misaligned)
            state_next = DONE;
          else if (!bus.wr)
            state_next = LOAD;
          else if (bus.size[1])
            state_next = STORE;
          else
            state_next = RMW_RD;
        end
      end
      LOAD:    state_next = DONE;
      STORE:   state_next = DONE;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latching, load capture and read-modify-write capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_reg    <= 1'b0;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      err_reg   <= 1'b0;
      rdata_reg <= 32'd0;
      merge_reg <= 32'd0;
    end else begin
      if (state_reg == IDLE && bus.req) begin
        wr_reg    <= bus.wr;
        size_reg  <= bus.size;
        uns_reg   <= bus.uns;
        addr_reg  <= bus.addr;
        wdata_reg <= bus.wdata;
        err_reg   <= misaligned;
      end
      if (state_reg == LOAD)
        rdata_reg <= load_data;
      if (state_reg == RMW_RD)
        merge_reg <= merge_data;
    end
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.err       = (state_reg == DONE) && err_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.mem_we    = ((state_reg == STORE) || (state_reg == RMW_WR)) && wr_reg;
  assign bus.mem_addr  = (state_reg == IDLE) ? bus.addr : addr_reg;
  assign bus.mem_wdata = (state_reg == RMW_WR) ? merge_reg : wdata_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the LSU: stimulus pushes expected completions and
// memory writes into queues; monitors pop and compare on done / mem_we.
module tb_lsu;

  logic clk;
  logic rst;
  logic init_mem;
  int   cyc;
  int   checks;
  int   failures;

  lsu_if bus ();

  lsu #(.CHECK_ALIGN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_done_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_wr_t;

  exp_done_t   done_q[$];
  exp_wr_t     wr_q[$];
  exp_done_t   mon_d;
  exp_wr_t     mon_w;
  logic [7:0]  mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-addressed memory model; only the low 8 address bits are used.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'hA5;
      mem[8'h11] <= 8'hF0;
      mem[8'h12] <= 8'h70;
      mem[8'h13] <= 8'h80;
    end else if (bus.mem_we) begin
      for (int i = 0; i < 4; i++)
        mem[bus.mem_addr[7:0] + 8'(i)] <= bus.mem_wdata[8*i +: 8];
    end
  end

  assign bus.mem_rdata = {mem[bus.mem_addr[7:0] + 8'd3], mem[bus.mem_addr[7:0] + 8'd2],
                          mem[bus.mem_addr[7:0] + 8'd1], mem[bus.mem_addr[7:0]]};

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
    end
  endfunction

  // Completion monitor: every done must match the oldest expected completion.
  always @(negedge clk) begin
    if (bus.done) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 cyc=%0d", cyc);
      end else begin
        mon_d = done_q.pop_front();
        $display("done cyc=%0d err=%0b rdata=%h", cyc, bus.err, bus.rdata);
        chk("done_err", {31'd0, bus.err}, {31'd0, mon_d.err});
        chk("done_rdata", bus.rdata, mon_d.rdata);
        chk("done_cycle", cyc, mon_d.cyc);
      end
    end
  end

  // Write monitor: every mem_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_mem_we actual=1 expected=0 addr=%h cyc=%0d", bus.mem_addr, cyc);
      end else begin
        mon_w = wr_q.pop_front();
        chk("wr_addr", bus.mem_addr, mon_w.addr);
        chk("wr_data", bus.mem_wdata, mon_w.data);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy expected=idle cyc=%0d", cyc);
    end
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rdata, input int lat,
                        input logic e_we, input logic [31:0] e_wdata);
    wait_idle();
    bus.req   = 1'b1;
    bus.wr    = w;
    bus.size  = sz;
    bus.uns   = u;
    bus.addr  = a;
    bus.wdata = wd;
    done_q.push_back('{e_err, e_rdata, cyc + lat});
    if (e_we) wr_q.push_back('{a, e_wdata});
    @(negedge clk);
    bus.req = 1'b0;
    wait_idle();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    init_mem  = 1'b1;
    bus.req   = 1'b0;
    bus.wr    = 1'b0;
    bus.size  = 2'b00;
    bus.uns   = 1'b0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
    rst       = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Loads from A5,F0,70,80 at 0x10
    access(0, 2'b00, 0, 32'h10, 0, 0, 32'hFFFFFFA5, 2, 0, 0);
    access(0, 2'b00, 1, 32'h11, 0, 0, 32'h000000F0, 2, 0, 0);
    access(0, 2'b01, 0, 32'h12, 0, 0, 32'hFFFF8070, 2, 0, 0);
    access(0, 2'b01, 1, 32'h12, 0, 0, 32'h00008070, 2, 0, 0);
    access(0, 2'b10, 0, 32'h10, 0, 0, 32'h8070F0A5, 2, 0, 0);
    // Byte store by read-modify-write: word at 0x11 is 0x008070F0
    access(1, 2'b00, 0, 32'h11, 32'h12345655, 0, 32'h8070F0A5, 3, 1, 32'h00807055);
    access(0, 2'b10, 0, 32'h10, 0, 0, 32'h807055A5, 2, 0, 0);
    // Misaligned accesses: rejected, no write, rdata held
    access(1, 2'b10, 0, 32'h13, 32'hFFFFFFFF, 1, 32'h807055A5, 1, 0, 0);
    access(0, 2'b01, 0, 32'h11, 0, 1, 32'h807055A5, 1, 0, 0);
    access(0, 2'b10, 0, 32'h12, 0, 1, 32'h807055A5, 1, 0, 0);
    access(0, 2'b11, 0, 32'h11, 0, 1, 32'h807055A5, 1, 0, 0);
    // Word store, then halfword merge into it
    access(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 0, 32'h807055A5, 2, 1, 32'hDEADBEEF);
    access(1, 2'b01, 0, 32'h20, 32'h9999CAFE, 0, 32'h807055A5, 3, 1, 32'hDEADCAFE);
    access(0, 2'b10, 0, 32'h20, 0, 0, 32'hDEADCAFE, 2, 0, 0);
    access(0, 2'b00, 0, 32'h23, 0, 0, 32'hFFFFFFDE, 2, 0, 0);
    access(0, 2'b00, 1, 32'h21, 0, 0, 32'h000000CA, 2, 0, 0);
    access(0, 2'b01, 1, 32'h22, 0, 0, 32'h0000DEAD, 2, 0, 0);
    access(0, 2'b01, 0, 32'h22, 0, 0, 32'hFFFFDEAD, 2, 0, 0);
    // Full 32-bit address passes through; memory sees only the low byte
    access(1, 2'b10, 0, 32'hABCD0130, 32'h01020304, 0, 32'hFFFFDEAD, 2, 1, 32'h01020304);
    access(0, 2'b10, 0, 32'hFFFFFF30, 0, 0, 32'h01020304, 2, 0, 0);
    access(0, 2'b11, 1, 32'h10, 0, 0, 32'h807055A5, 2, 0, 0);

    // req held high: one accept per IDLE visit, no extra completions
    wait_idle();
    bus.req  = 1'b1;
    bus.wr   = 1'b0;
    bus.size = 2'b10;
    bus.uns  = 1'b0;
    bus.addr = 32'h10;
    done_q.push_back('{1'b0, 32'h807055A5, cyc + 2});
    done_q.push_back('{1'b0, 32'h807055A5, cyc + 5});
    done_q.push_back('{1'b0, 32'h807055A5, cyc + 8});
    repeat (9) @(negedge clk);
    bus.req = 1'b0;
    wait_idle();

    // Reset in RMW_RD of a halfword store at 0x20 aborts it silently
    bus.req   = 1'b1;
    bus.wr    = 1'b1;
    bus.size  = 2'b01;
    bus.addr  = 32'h20;
    bus.wdata = 32'h00001111;
    @(posedge clk);
    #2;
    bus.req = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_rdata", bus.rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_mem20", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'hDEADCAFE);
    access(0, 2'b10, 0, 32'h20, 0, 0, 32'hDEADCAFE, 2, 0, 0);

    repeat (5) @(negedge clk);
    chk("pending_done", done_q.size(), 32'd0);
    chk("pending_writes", wr_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: CHECK_ALIGN, default 1, meaning: 1 = flag misaligned halfword/word accesses as errors; 0 = no alignment check, access always issued.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  CPU access request; sampled only when busy=0.
REQ-005 wr  input  1  1 = store, 0 = load.
REQ-006 size  input  2  access size: 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
REQ-007 uns  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, right-aligned in the low bits.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  valid with done; 1 = access rejected as misaligned.
REQ-013 rdata  output  32  extended load result; valid while done=1 and held afterwards.
REQ-014 mem_we  output  1  write enable to the word data memory.
REQ-015 mem_addr  output  32  byte address to the memory; memory uses bits [7:0].
REQ-016 mem_wdata  output  32  little-endian word to the memory; byte 0 goes to mem_addr.
REQ-017 mem_rdata  input  32  combinational little-endian read of bytes mem_addr..mem_addr+3.

Function
REQ-018 The LSU SHALL implement the states IDLE, LOAD, STORE, RMW_RD, RMW_WR and DONE.
REQ-019 In IDLE with req=1, the LSU SHALL latch wr, size, uns, addr and wdata, and SHALL select the next state:
- Misaligned: DONE with err=1.
- Load: LOAD.
- Word store: STORE.
- Byte or halfword store: RMW_RD.
REQ-020 Misaligned SHALL mean either of the following, and SHALL apply only when CHECK_ALIGN=1:
- halfword with addr[0]=1;
- word with addr[1:0]!=0.
REQ-021 The LOAD state SHALL drive mem_addr with the latched addr, and SHALL capture mem_rdata at the clock edge that leaves the state.
REQ-022 On the LOAD capture, rdata SHALL be formed as follows:
- Byte: mem_rdata[7:0], extended per uns.
- Halfword: mem_rdata[15:0], extended per uns.
- Word: mem_rdata unchanged.
REQ-023 STORE SHALL assert mem_we=1 for exactly one cycle, with mem_wdata equal to the latched wdata.
REQ-024 RMW_RD SHALL capture mem_rdata. RMW_WR SHALL then assert mem_we=1 for one cycle with a merged word:
- Byte: low byte replaced by wdata[7:0].
- Halfword: low half replaced by wdata[15:0].
- All remaining bytes unchanged.
REQ-025 DONE SHALL assert done=1 for one cycle, SHALL assert err=1 only for rejected accesses, and SHALL return to IDLE.
REQ-026 Latency from the req edge to done: error 1 cycle; load 2; word store 2; byte or halfword store 3.
REQ-027 mem_we SHALL be 1 only in STORE and RMW_RD→RMW_WR's RMW_WR state; a rejected access SHALL never assert mem_we.
REQ-028 req while busy=1 SHALL be ignored, and SHALL not be queued.
REQ-029 A new req sampled in the same cycle the LSU returns to IDLE SHALL be accepted (back-to-back accesses, one IDLE cycle between them).
REQ-030 On an error, rdata SHALL hold its previous value.
REQ-031 Address wrap above 0xFF SHALL be left to the memory; the LSU SHALL pass the full 32-bit address unmodified.
REQ-032 mem_addr SHALL equal the latched addr in all non-IDLE states, and SHALL equal the addr input in IDLE.

Reset
REQ-033 rst=0 SHALL immediately force state=IDLE, busy=0, done=0, err=0, mem_we=0 and rdata=0, independent of clk.
REQ-034 Reset asserted mid-operation SHALL abort the access; no mem_we SHALL occur after rst falls, and no done SHALL be issued for the aborted access.

Verification
REQ-035 With memory 0x10..0x13 = A5,F0,70,80:
- LB 0x10 → rdata 0xFFFFFFA5 at done, 2 cycles after req.
- LBU 0x11 → rdata 0x000000F0.
REQ-036 Same memory, LH 0x12 → rdata 0xFFFF8070; LHU 0x12 → 0x00008070; LW 0x10 → 0x8070F0A5.
REQ-037 SB 0x11 with wdata=0x12345655 → a single mem_we pulse in cycle 2, then done in cycle 3; a following LW 0x10 → 0x807055A5 (address 0x11, byte order A5,55,70,80 at 0x10).
REQ-038 SW 0x13 with CHECK_ALIGN=1 → done=1, err=1 in cycle 1, mem_we never asserted, rdata unchanged.
REQ-039 rst=0 during RMW_RD of SH 0x20 → mem_we stays 0, busy=0 at once, memory at 0x20 unchanged, no done pulse.
REQ-040 req held high continuously → accesses complete back-to-back; any req asserted while busy=1 produces no extra done.
